pwm_deadtime_gen: RTL and testbench

Dead-time insertion stage directly downstream of the PWM controller's raw `pwm_o` outputs. It converts each raw PWM channel into a complementary high-side/low-side gate-drive pair. Both switches are guaranteed off for a programmable number of cycles around every edge. A latched fault shutdown forces all gates off. It sits between the controller and the pad ring or gate drivers, in the controller's clock domain.

---
 rtl/pwm_deadtime_gen.sv | 166 ++++++++++++++++
 tb/tb_pwm_deadtime_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_gen.sv
// Per-channel complementary gate drive with dead-time insertion and fault shutdown.
// Optional PWM_DT_FAULT_SYNC_EN adds a 2-flop synchronizer on fault_i.
module pwm_deadtime_gen #(
  parameter int NUM_CH = 8,
  parameter int DT_W   = 8
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              en_i,
  input  logic [NUM_CH-1:0] pwm_i,
  input  logic [DT_W-1:0]   dt_rise_i,
  input  logic [DT_W-1:0]   dt_fall_i,
  input  logic              fault_i,
  input  logic              fault_clr_i,
  output logic [NUM_CH-1:0] pwm_h_o,
  output logic [NUM_CH-1:0] pwm_l_o,
  output logic              fault_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_OFF,
    S_LOW,
    S_DT_RISE,
    S_HIGH,
    S_DT_FALL
  } state_e;

  state_e            st_q  [NUM_CH];
  state_e            st_d  [NUM_CH];
  logic [DT_W-1:0]   cnt_q [NUM_CH];
  logic [DT_W-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q;
  logic [NUM_CH-1:0] h_q, h_d;
  logic [NUM_CH-1:0] l_q, l_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic              fault_s;
  logic              kill;

`ifdef PWM_DT_FAULT_SYNC_EN
  logic [1:0] fsync_q, fsync_d;

  always_comb begin
    fsync_d = {fsync_q[0], fault_i};
    fault_s = fsync_q[1];
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      fsync_q <= '0;
    end else begin
      fsync_q <= fsync_d;
    end
  end
`else
  always_comb begin
    fault_s = fault_i;
  end
`endif

  // Set beats clear; the FSMs see the next fault value so shutdown lands on the latching edge.
  always_comb begin
    fault_d = fault_s | (fault_q & ~fault_clr_i);
    kill    = ~en_i | fault_d;
  end

  always_comb begin
    h_d    = '0;
    l_d    = '0;
    busy_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (kill) begin
        st_d[i]  = S_OFF;
        cnt_d[i] = '0;
      end else begin
        unique case (st_q[i])
          S_OFF: begin
            if (dt_fall_i == '0) begin
              st_d[i] = pwm_q[i] ? S_HIGH : S_LOW;
            end else begin
              st_d[i]  = S_DT_FALL;
              cnt_d[i] = dt_fall_i;
            end
          end
          S_LOW: begin
            if (pwm_q[i]) begin
              if (dt_rise_i == '0) begin
                st_d[i] = S_HIGH;
              end else begin
                st_d[i]  = S_DT_RISE;
                cnt_d[i] = dt_rise_i;
              end
            end
          end
          S_DT_RISE: begin
            if (!pwm_q[i]) begin
              st_d[i] = S_LOW;
            end else if (cnt_q[i] <= DT_W'(1)) begin
              st_d[i] = S_HIGH;
            end else begin
              cnt_d[i] = cnt_q[i] - DT_W'(1);
            end
          end
          S_HIGH: begin
            if (!pwm_q[i]) begin
              if (dt_fall_i == '0) begin
                st_d[i] = S_LOW;
              end else begin
                st_d[i]  = S_DT_FALL;
                cnt_d[i] = dt_fall_i;
              end
            end
          end
          S_DT_FALL: begin
            if (cnt_q[i] <= DT_W'(1)) begin
              st_d[i] = pwm_q[i] ? S_HIGH : S_LOW;
            end else begin
              cnt_d[i] = cnt_q[i] - DT_W'(1);
            end
          end
          default: begin
            st_d[i] = S_OFF;
          end
        endcase
      end
      h_d[i] = (st_d[i] == S_HIGH);
      l_d[i] = (st_d[i] == S_LOW);
      if (st_d[i] == S_DT_RISE || st_d[i] == S_DT_FALL) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= S_OFF;
        cnt_q[i] <= '0;
      end
      pwm_q   <= '0;
      h_q     <= '0;
      l_q     <= '0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pwm_q   <= pwm_i;
      h_q     <= h_d;
      l_q     <= l_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign pwm_h_o = h_q;
  assign pwm_l_o = l_q;
  assign fault_o = fault_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Bench for pwm_deadtime_gen: vector table, corner sequences, random run vs. deadline model.
module tb_pwm_deadtime_gen;

`ifdef PWM_DT_FAULT_SYNC_EN
  localparam int FLAT = 3;
  localparam bit SYNC = 1'b1;
`else
  localparam int FLAT = 1;
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] pwm = '0;
  logic [7:0] dtr = 8'd4;
  logic [7:0] dtf = 8'd3;
  logic       fi = 1'b0;
  logic       fclr = 1'b0;
  logic [7:0] h, l;
  logic       fo, busy;

  int checks = 0;
  int errors = 0;
  int prints = 0;

  always #5 clk = ~clk;

  pwm_deadtime_gen #(.NUM_CH(8), .DT_W(8)) dut (
    .pclk_i(clk), .preset_i(rst), .en_i(en), .pwm_i(pwm),
    .dt_rise_i(dtr), .dt_fall_i(dtf), .fault_i(fi),
    .fault_clr_i(fclr), .pwm_h_o(h), .pwm_l_o(l),
    .fault_o(fo), .busy_o(busy)
  );

  // Model: mode 0 off, 1 low on, 2 high on, 3 gap until absolute edge 'due'.
  int     mode [8];
  int     goal [8];
  longint due  [8];
  bit [7:0] mpq;
  bit     mf;
  bit     fh [2];
  longint n = 0;

  task automatic enter(input int ch, input int g, input int d);
    if (d == 0) begin
      mode[ch] = (g == 1 && mpq[ch]) ? 2 : g;
    end else begin
      mode[ch] = 3;
      goal[ch] = g;
      due[ch]  = n + d;
    end
  endtask

  task automatic model_step();
    bit fs, fnext;
    n++;
    if (rst) begin
      for (int c = 0; c < 8; c++) mode[c] = 0;
      mpq = '0; mf = 0; fh[0] = 0; fh[1] = 0;
      return;
    end
    fs = SYNC ? fh[1] : fi;
    fh[1] = fh[0];
    fh[0] = fi;
    fnext = fs | (mf & !fclr);
    for (int c = 0; c < 8; c++) begin
      if (!en || fnext) mode[c] = 0;
      else if (mode[c] == 0) enter(c, 1, int'(dtf));
      else if (mode[c] == 1) begin
        if (mpq[c]) enter(c, 2, int'(dtr));
      end else if (mode[c] == 2) begin
        if (!mpq[c]) enter(c, 1, int'(dtf));
      end else begin
        if (goal[c] == 2 && !mpq[c]) mode[c] = 1;
        else if (n == due[c]) mode[c] = (goal[c] == 1 && mpq[c]) ? 2 : goal[c];
      end
    end
    mf = fnext;
    mpq = pwm;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at edge %0d", nm, act, exp, n);
    end
  endtask

  task automatic cyc();
    logic [7:0] eh, el;
    logic eb;
    @(posedge clk);
    model_step();
    eh = '0; el = '0; eb = 0;
    for (int c = 0; c < 8; c++) begin
      eh[c] = (mode[c] == 2);
      el[c] = (mode[c] == 1);
      if (mode[c] == 3) eb = 1;
    end
    @(negedge clk);
    checks++;
    if ({h, l, fo, busy} !== {eh, el, mf, eb}) begin
      errors++;
      if (prints < 30) begin
        prints++;
        $display("FAIL model edge %0d got h=%h l=%h f=%b b=%b expected h=%h l=%h f=%b b=%b",
                 n, h, l, fo, busy, eh, el, mf, eb);
      end
    end
    checks++;
    if ((h & l) != 0) begin
      errors++;
      $display("FAIL overlap edge %0d got h=%h l=%h expected disjoint", n, h, l);
    end
  endtask

  typedef struct {
    bit       rst, en, p0;
    bit [7:0] dtr, dtf;
    bit       eh, el, eb;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1, 0, 0, 4, 3, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 4, 3, 0, 0, 1};
    tbl[2]  = '{0, 1, 0, 4, 3, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 4, 3, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 4, 3, 0, 1, 0};
    tbl[5]  = '{0, 1, 1, 4, 3, 0, 1, 0};
    tbl[6]  = '{0, 1, 1, 4, 3, 0, 0, 1};
    tbl[7]  = '{0, 1, 1, 4, 3, 0, 0, 1};
    tbl[8]  = '{0, 1, 1, 4, 3, 0, 0, 1};
    tbl[9]  = '{0, 1, 1, 4, 3, 0, 0, 1};
    tbl[10] = '{0, 1, 1, 4, 3, 1, 0, 0};
    tbl[11] = '{0, 1, 0, 4, 3, 1, 0, 0};
    tbl[12] = '{0, 1, 0, 4, 3, 0, 0, 1};
    tbl[13] = '{0, 1, 0, 4, 3, 0, 0, 1};
    tbl[14] = '{0, 1, 0, 4, 3, 0, 0, 1};
    tbl[15] = '{0, 1, 0, 4, 3, 0, 1, 0};
    tbl[16] = '{0, 1, 1, 0, 0, 0, 1, 0};
    tbl[17] = '{0, 1, 1, 0, 0, 1, 0, 0};
    tbl[18] = '{0, 1, 0, 0, 0, 1, 0, 0};
    tbl[19] = '{0, 1, 0, 0, 0, 0, 1, 0};

    for (int r = 0; r < 20; r++) begin
      rst = tbl[r].rst; en = tbl[r].en; pwm = {7'b0, tbl[r].p0};
      dtr = tbl[r].dtr; dtf = tbl[r].dtf;
      cyc();
      chk($sformatf("tbl%0d_h0", r), 32'(h[0]), 32'(tbl[r].eh));
      chk($sformatf("tbl%0d_l0", r), 32'(l[0]), 32'(tbl[r].el));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].eb));
      chk($sformatf("tbl%0d_fault", r), 32'(fo), 32'd0);
    end

    // runt pulse shorter than the rise window
    dtr = 8'd6; dtf = 8'd3; pwm = 8'h01;
    cyc();
    cyc();
    chk("runt_l_drop", 32'(l[0]), 32'd0);
    pwm = 8'h00;
    cyc();
    chk("runt_gap_h", 32'(h[0]), 32'd0);
    cyc();
    chk("runt_l_back", 32'(l[0]), 32'd1);
    chk("runt_busy", 32'(busy), 32'd0);

    // fault while high
    dtr = 8'd2; pwm = 8'h01;
    repeat (5) cyc();
    chk("pre_fault_h", 32'(h[0]), 32'd1);
    fi = 1'b1;
    for (int j = 0; j < FLAT; j++) begin
      cyc();
      fi = 1'b0;
      if (j < FLAT - 1) chk("fault_wait_h", 32'(h[0]), 32'd1);
      else begin
        chk("fault_set", 32'(fo), 32'd1);
        chk("fault_gates", 32'({h, l}), 32'd0);
      end
    end
    repeat (5) cyc();
    chk("fault_hold", 32'({fo, h, l}), 32'h10000);
    fi = 1'b1;
    repeat (4) cyc();
    fclr = 1'b1;
    cyc();
    fclr = 1'b0;
    chk("clr_ignored", 32'(fo), 32'd1);
    fi = 1'b0; pwm = 8'h00;
    repeat (5) cyc();
    chk("fault_still", 32'(fo), 32'd1);
    fclr = 1'b1;
    cyc();
    fclr = 1'b0;
    chk("clr_fault", 32'(fo), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);
    cyc();
    cyc();
    chk("clr_l_wait", 32'(l), 32'd0);
    cyc();
    chk("clr_l_on", 32'(l), 32'hFF);

    // disable inside a rise window
    dtr = 8'd5; pwm = 8'h01;
    cyc();
    cyc();
    chk("dis_in_rise", 32'(busy), 32'd1);
    en = 1'b0;
    cyc();
    chk("dis_out", 32'({h, l, busy}), 32'd0);
    en = 1'b1; pwm = 8'h00;
    repeat (3) cyc();
    chk("en_l_wait", 32'(l), 32'd0);
    cyc();
    chk("en_l_on", 32'(l), 32'hFF);

    // reset while high
    dtr = 8'd1; pwm = 8'h01;
    repeat (3) cyc();
    chk("pre_rst_h", 32'(h[0]), 32'd1);
    rst = 1'b1;
    cyc();
    chk("rst_out", 32'({h, l, fo, busy}), 32'd0);
    rst = 1'b0; pwm = 8'h00; dtf = 8'd3;
    repeat (3) cyc();
    chk("rst_l_wait", 32'(l), 32'd0);
    cyc();
    chk("rst_l_on", 32'(l), 32'hFF);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 8; c++)
        if ($urandom % 6 == 0) pwm[c] = ~pwm[c];
      if ($urandom % 50 == 0) begin
        dtr = 8'($urandom % 8);
        dtf = 8'($urandom % 8);
      end
      en   = ($urandom % 150) != 0;
      fi   = ($urandom % 250) == 0;
      fclr = ($urandom % 30) == 0;
      rst  = ($urandom % 600) == 0;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
